// File: rtl/fifo_ext.sv
// fifo_ext: parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, flush and read-while-full.
//
// Build option: define FIFO_FWFT_EN for first-word fall-through output. When it is
// undefined, data_out is registered with one cycle of read latency.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset (highest priority)
//   wr, rd       write / read requests
//   flush        synchronously empties the FIFO; wr/rd/clear_err ignored that cycle
//   clear_err    clears the sticky overflow/underflow flags
//   data_in      write data
//   data_out     read data (registered, or head-of-queue in FWFT mode)
//   empty, full  occupancy == 0 / == FIFO_DEPTH
//   almost_empty count <= AE_LEVEL
//   almost_full  count >= AF_LEVEL
//   count        occupancy 0..FIFO_DEPTH
//   overflow     sticky: a write was dropped
//   underflow    sticky: a read hit an empty FIFO
module fifo_ext #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AF_LEVEL   = 3,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr,
    input  logic                          rd,
    input  logic                          flush,
    input  logic                          clear_err,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic                  empty_q, empty_d;
    logic                  full_q, full_d;
    logic                  ae_q, ae_d;
    logic                  af_q, af_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic rd_ok, wr_ok, ovf_set, unf_set;

    // A write into a full FIFO is still accepted when a read frees a slot the same edge.
    always_comb begin
        rd_ok   = rd & ~empty_q;
        wr_ok   = wr & (~full_q | rd);
        ovf_set = wr & full_q & ~rd;
        unf_set = rd & empty_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        dout_d   = dout_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (rd_ok) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                dout_d   = mem[rd_ptr_q];
            end
            unique case ({wr_ok, rd_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
            // Setting wins over clearing in the same cycle.
            ovf_d = ovf_set | (ovf_q & ~clear_err);
            unf_d = unf_set | (unf_q & ~clear_err);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
        ae_d    = (count_d <= AE_C);
        af_d    = (count_d >= AF_C);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ae_q     <= 1'b1;
            af_q     <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            ae_q     <= ae_d;
            af_q     <= af_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            dout_q   <= dout_d;
        end
    end

    // Storage is not reset.
    always_ff @(posedge clk) begin
        if (!reset && !flush && wr_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word falls through while non-empty; dout_q keeps the last popped word.
    always_comb data_out = empty_q ? dout_q : mem[rd_ptr_q];
`else
    always_comb data_out = dout_q;
`endif

    always_comb begin
        empty        = empty_q;
        full         = full_q;
        almost_empty = ae_q;
        almost_full  = af_q;
        count        = count_q;
        overflow     = ovf_q;
        underflow    = unf_q;
    end

endmodule

// File: tb/tb_fifo_ext.sv
module tb_fifo_ext;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          reset, wr, rd, flush, clear_err;
    logic [DW-1:0] data_in, data_out;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;
    logic [2:0]    count;

    fifo_ext #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .AF_LEVEL   (AF),
        .AE_LEVEL   (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr           (wr),
        .rd           (rd),
        .flush        (flush),
        .clear_err    (clear_err),
        .data_in      (data_in),
        .data_out     (data_out),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt;
        bit e, f, ae, af, ov, un;
        int dout;
        int step;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: plain queue of words plus sticky flags and last output word.
    int m_q[$];
    int m_dout = 0;
    bit m_ov = 0, m_un = 0;
    int step_no = 0;

    task automatic cmp(input string name, input int step, input int act, input int req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, req);
    endtask

    task automatic step(input bit r, input bit f, input bit w, input bit rq, input bit c,
                        input int din);
        exp_t e;
        int   sz;
        @(negedge clk);
        reset = r; flush = f; wr = w; rd = rq; clear_err = c; data_in = din[DW-1:0];
        sz = m_q.size();
        if (r) begin
            m_q.delete(); m_dout = 0; m_ov = 0; m_un = 0;
        end else if (f) begin
            m_q.delete();
        end else begin
            bit rd_ok, wr_ok;
            rd_ok = rq && sz > 0;
            wr_ok = w && (sz < DEPTH || rq);
            m_ov = (w && sz == DEPTH && !rq) || (m_ov && !c);
            m_un = (rq && sz == 0) || (m_un && !c);
            if (rd_ok) m_dout = m_q.pop_front();
            if (wr_ok) m_q.push_back(din & 8'hFF);
        end
        sz    = m_q.size();
        e.cnt = sz;
        e.e   = (sz == 0);
        e.f   = (sz == DEPTH);
        e.ae  = (sz <= AE);
        e.af  = (sz >= AF);
        e.ov  = m_ov;
        e.un  = m_un;
`ifdef FIFO_FWFT_EN
        e.dout = (sz > 0) ? m_q[0] : m_dout;
`else
        e.dout = m_dout;
`endif
        e.step = step_no++;
        exp_q.push_back(e);
    endtask

    task automatic wr_only(input int d); step(0, 0, 1, 0, 0, d); endtask
    task automatic rd_only();            step(0, 0, 0, 1, 0, 0); endtask
    task automatic idle();               step(0, 0, 0, 0, 0, 0); endtask

    // Monitor: compares each registered state update one step after the stimulus.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp("count",        e.step, int'(count),        e.cnt);
            cmp("empty",        e.step, int'(empty),        int'(e.e));
            cmp("full",         e.step, int'(full),         int'(e.f));
            cmp("almost_empty", e.step, int'(almost_empty), int'(e.ae));
            cmp("almost_full",  e.step, int'(almost_full),  int'(e.af));
            cmp("overflow",     e.step, int'(overflow),     int'(e.ov));
            cmp("underflow",    e.step, int'(underflow),    int'(e.un));
            cmp("data_out",     e.step, int'(data_out),     e.dout);
        end
    end

    initial begin
        reset = 1'b1; wr = 1'b0; rd = 1'b0; flush = 1'b0; clear_err = 1'b0; data_in = '0;

        // Reset state, then fill to full.
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) wr_only(i);
        // Dropped write, then drain with one-cycle data latency.
        wr_only(4);
        for (int i = 0; i < 4; i++) rd_only();
        idle();
        // Read on empty, then clear errors.
        rd_only();
        step(0, 0, 0, 0, 1, 0);
        // Refill across pointer wrap, then simultaneous write+read while full.
        for (int i = 10; i < 14; i++) wr_only(i);
        step(0, 0, 1, 1, 0, 14);
        for (int i = 0; i < 4; i++) rd_only();
        // Empty + rd + wr: write accepted, underflow set.
        step(0, 0, 1, 1, 0, 8'h77);
        step(0, 0, 0, 0, 1, 0);
        rd_only();
        // Flush discards contents.
        wr_only(8'hAA);
        wr_only(8'hBB);
        step(0, 1, 1, 1, 1, 8'h99);
        wr_only(8'hCC);
        rd_only();
        idle();
        // Overflow set and clear_err in the same cycle: set wins.
        for (int i = 0; i < 4; i++) wr_only(8'h40 + i);
        step(0, 0, 1, 0, 1, 8'h50);
        idle();

        // Randomized traffic with occasional flush, clear_err and reset.
        for (int i = 0; i < 1500; i++) begin
            bit r, f, w, rq, c;
            r  = ($urandom_range(0, 199) == 0);
            f  = ($urandom_range(0, 49) == 0);
            c  = ($urandom_range(0, 19) == 0);
            w  = ($urandom_range(0, 99) < 55);
            rq = ($urandom_range(0, 99) < 45);
            step(r, f, w, rq, c, int'($urandom_range(0, 255)));
        end
        idle();

        @(posedge clk);
        #3;
        cmp("scoreboard_drained", step_no, exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
